wb_sdram_arbiter: RTL and testbench

Round-robin Wishbone (classic, single-slave) arbiter that shares the SDRAM controller's slave port between `NUM_MASTERS` requesters, such as the DSP capture engine, CPU and DMA. It sits between the masters and the `wh_ifc` side of the SDRAM agent. It grants one master per bus cycle (per `cyc` assertion), muxes address, data and control to the slave, and routes `ack` back to the owner. An optional watchdog aborts cycles the SDRAM never acknowledges.

---
 rtl/wb_sdram_arbiter_pkg.sv | 31 +++
 rtl/wb_sdram_arbiter_if.sv | 50 +++++
 rtl/wb_sdram_arbiter_rr.sv | 34 +++
 rtl/wb_sdram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_sdram_arbiter_pkg.sv
// wb_arb_pkg: shared types, default parameter values and helpers for the
// Wishbone SDRAM arbiter slice.
//   arb_state_e     : arbiter FSM states (IDLE, GRANT)
//   DEF_*           : default NUM_MASTERS / AW / DW / TIMEOUT_CYCLES
//   MAX_MASTERS     : widest supported requester count
//   onehot_to_idx() : one-hot (up to MAX_MASTERS bits) to binary index
package wb_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_MASTERS    = 4;
   localparam int DEF_AW             = 24;
   localparam int DEF_DW             = 32;
   localparam int DEF_TIMEOUT_CYCLES = 255;
   localparam int MAX_MASTERS        = 8;

   // All-zero input maps to index 0; callers only use the result when a
   // bit is set.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
         if (onehot[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_sdram_arbiter_if.sv
// wb_sdram_arbiter_if: bundle of all requester-side and SDRAM-side Wishbone
// signals around the arbiter.
//   modport slave  : the arbiter's view (takes master requests and slave
//                    responses, drives acks/errors/read data and the slave bus)
//   modport master : the environment's view (masters plus SDRAM agent)
// Packed per-master vectors: master k occupies [k*W +: W].
interface wb_sdram_arbiter_if import wb_arb_pkg::*; #(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int AW          = DEF_AW,
   parameter int DW          = DEF_DW
);

   logic [NUM_MASTERS-1:0]        m_cyc_i;
   logic [NUM_MASTERS-1:0]        m_stb_i;
   logic [NUM_MASTERS-1:0]        m_we_i;
   logic [NUM_MASTERS*AW-1:0]     m_adr_i;
   logic [NUM_MASTERS*DW-1:0]     m_dat_i;
   logic [NUM_MASTERS*DW/8-1:0]   m_sel_i;
   logic [NUM_MASTERS-1:0]        m_ack_o;
   logic [NUM_MASTERS-1:0]        m_err_o;
   logic [DW-1:0]                 m_dat_o;

   logic                          s_cyc_o;
   logic                          s_stb_o;
   logic                          s_we_o;
   logic [AW-1:0]                 s_adr_o;
   logic [DW-1:0]                 s_dat_o;
   logic [DW/8-1:0]               s_sel_o;
   logic [DW-1:0]                 s_dat_i;
   logic                          s_ack_i;

   logic [NUM_MASTERS-1:0]        grant_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      input  s_dat_i, s_ack_i,
      output m_ack_o, m_err_o, m_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output grant_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      output s_dat_i, s_ack_i,
      input  m_ack_o, m_err_o, m_dat_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  grant_o
   );

endinterface

// File: rtl/wb_sdram_arbiter_rr.sv
// wb_rr_arbiter: combinational round-robin picker.
//   req        in  NUM_MASTERS      : eligible requests
//   last_grant in  $clog2(NUM_MASTERS) : index of the previous winner
//   gnt        out NUM_MASTERS      : one-hot winner (0 when no request)
// The search begins at last_grant+1 and wraps modulo NUM_MASTERS, so the
// previous winner has the lowest priority.
module wb_rr_arbiter import wb_arb_pkg::*; #(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
   input  logic [NUM_MASTERS-1:0]         req,
   input  logic [$clog2(NUM_MASTERS)-1:0] last_grant,
   output logic [NUM_MASTERS-1:0]         gnt
);

   localparam int          IW = $clog2(NUM_MASTERS);
   localparam int unsigned N  = NUM_MASTERS;

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = IW'((32'(last_grant) + i) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: round-robin Wishbone classic arbiter sharing one SDRAM
// slave port between NUM_MASTERS requesters.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : wb_sdram_arbiter_if.slave -- per-master cyc/stb/we/adr/dat/sel
//           in, per-master ack/err out, broadcast read data, muxed slave
//           bus out, slave ack/read data in, one-hot grant_o for debug.
// One master owns the bus for the whole of its cyc assertion; no preemption.
// Optional feature macro WB_ARB_TIMEOUT_EN: watchdog that aborts a cycle the
// slave never acknowledges after TIMEOUT_CYCLES stalled strobe cycles and
// pulses m_err_o for the owner. Without it m_err_o is tied to 0.
module wb_sdram_arbiter import wb_arb_pkg::*; #(
   parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
   parameter int AW             = DEF_AW,
   parameter int DW             = DEF_DW,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk_i,
   input  logic              rst_i,
   wb_sdram_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam int SW = DW / 8;

   if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
      $error("wb_sdram_arbiter: NUM_MASTERS must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("wb_sdram_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   arb_state_e             state, state_n;
   logic [NUM_MASTERS-1:0] grant, grant_n;
   logic [NUM_MASTERS-1:0] winner;
   logic [NUM_MASTERS-1:0] eligible;
   logic [IW-1:0]          last_grant, last_grant_n;
   logic [IW-1:0]          own_idx;
   logic [MAX_MASTERS-1:0] grant_pad, winner_pad;
   logic                   expire;

   logic [AW-1:0]          adr_arr [NUM_MASTERS];
   logic [DW-1:0]          dat_arr [NUM_MASTERS];
   logic [SW-1:0]          sel_arr [NUM_MASTERS];

   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
      assign adr_arr[k] = bus.m_adr_i[k*AW +: AW];
      assign dat_arr[k] = bus.m_dat_i[k*DW +: DW];
      assign sel_arr[k] = bus.m_sel_i[k*SW +: SW];
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0]          wd_count;
   logic [NUM_MASTERS-1:0] blocked;

   // Fires on the TIMEOUT_CYCLES-th stalled strobe cycle; the edge closing
   // that cycle is where the count would reach the limit.
   assign expire = (state == GRANT) && bus.s_stb_o && !bus.s_ack_i &&
                   (wd_count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_count <= '0;
      end else if (state == IDLE || bus.s_ack_i) begin
         wd_count <= '0;
      end else if (bus.s_stb_o && wd_count != CW'(TIMEOUT_CYCLES)) begin
         wd_count <= wd_count + 1'b1;
      end
   end

   // A timed-out owner stays ineligible until its cyc has been seen low,
   // so a master that never backs off cannot immediately re-grab the bus.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         blocked <= '0;
      end else begin
         blocked <= (blocked & bus.m_cyc_i) | (expire ? grant : '0);
      end
   end

   assign eligible    = bus.m_cyc_i & ~blocked;
   assign bus.m_err_o = expire ? grant : '0;
`else
   assign expire      = 1'b0;
   assign eligible    = bus.m_cyc_i;
   assign bus.m_err_o = '0;
`endif

   wb_rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr (
      .req        (eligible),
      .last_grant (last_grant),
      .gnt        (winner)
   );

   always_comb begin
      grant_pad                     = '0;
      grant_pad[NUM_MASTERS-1:0]    = grant;
      winner_pad                    = '0;
      winner_pad[NUM_MASTERS-1:0]   = winner;
   end

   assign own_idx = IW'(onehot_to_idx(grant_pad));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IW'(NUM_MASTERS - 1);
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         last_grant <= last_grant_n;
      end
   end

   // Leaving GRANT always passes through one IDLE cycle, which guarantees a
   // gap with s_cyc_o low between consecutive owners.
   always_comb begin
      state_n      = state;
      grant_n      = grant;
      last_grant_n = last_grant;
      unique case (state)
         IDLE: begin
            if (|eligible) begin
               state_n      = GRANT;
               grant_n      = winner;
               last_grant_n = IW'(onehot_to_idx(winner_pad));
            end
         end
         GRANT: begin
            if (!bus.m_cyc_i[own_idx] || expire) begin
               state_n = IDLE;
               grant_n = '0;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_we_o  = 1'b0;
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_sel_o = '0;
      if (state == GRANT) begin
         bus.s_cyc_o = bus.m_cyc_i[own_idx];
         bus.s_stb_o = bus.m_stb_i[own_idx];
         bus.s_we_o  = bus.m_we_i[own_idx];
         bus.s_adr_o = adr_arr[own_idx];
         bus.s_dat_o = dat_arr[own_idx];
         bus.s_sel_o = sel_arr[own_idx];
      end
   end

   // grant is all-zero in IDLE, so a stray ack with no owner reaches no one.
   assign bus.m_ack_o = {NUM_MASTERS{bus.s_ack_i}} & grant & bus.m_stb_i;
   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.grant_o = grant;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed self-checking bench for wb_sdram_arbiter (4 masters, AW=24,
// DW=32). The watchdog scenario runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_sdram_arbiter;
   import wb_arb_pkg::*;

   localparam int NM = 4;
   localparam int AW = 24;
   localparam int DW = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   wb_sdram_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

   wb_sdram_arbiter #(
      .NUM_MASTERS    (NM),
      .AW             (AW),
      .DW             (DW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i  = '0;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_sel_i = '0;
      bus.s_dat_i = '0;
      bus.s_ack_i = 1'b0;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      bus.s_ack_i = 1'b1;
      bus.m_stb_i = 4'b1111;
      tick();
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant_o); end
      checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got %b want 0", bus.s_cyc_o); end
      checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_s_stb got %b want 0", bus.s_stb_o); end
      checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL reset_m_ack got %b want 0000", bus.m_ack_o); end
      checks++; if (bus.m_err_o !== 4'b0000) begin errors++; $display("FAIL reset_m_err got %b want 0000", bus.m_err_o); end
      tick();
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_master;
      logic [31:0] rd_data [4];
      logic [23:0] adr;
      int          ack_cnt;
      rd_data[0] = 32'hDEAD_BEEF;
      rd_data[1] = 32'h1234_5678;
      rd_data[2] = 32'hA5A5_0F0F;
      rd_data[3] = 32'h0000_0001;
      ack_cnt = 0;
      bus.m_cyc_i[2] = 1'b1;
      bus.m_stb_i[2] = 1'b1;
      bus.m_we_i[2]  = 1'b0;
      bus.m_adr_i[2*AW +: AW] = 24'h000100;
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL single_pregrant got %b want 0000", bus.grant_o); end
      tick();
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", bus.grant_o); end
      checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("FAIL single_s_cyc got %b want 1", bus.s_cyc_o); end
      checks++; if (bus.s_we_o !== 1'b0) begin errors++; $display("FAIL single_s_we got %b want 0", bus.s_we_o); end
      for (int b = 0; b < 4; b++) begin
         adr = 24'h000100 + 24'(b * 4);
         tick();
         bus.s_ack_i = 1'b0;
         bus.m_adr_i[2*AW +: AW] = adr;
         @(negedge clk);
         checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL single_stall_ack beat %0d got %b want 0000", b, bus.m_ack_o); end
         tick();
         tick();
         bus.s_ack_i = 1'b1;
         bus.s_dat_i = rd_data[b];
         @(negedge clk);
         checks++; if (bus.m_ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack beat %0d got %b want 0100", b, bus.m_ack_o); end
         checks++; if (bus.m_dat_o !== rd_data[b]) begin errors++; $display("FAIL single_rdata beat %0d got %h want %h", b, bus.m_dat_o, rd_data[b]); end
         checks++; if (bus.s_adr_o !== adr) begin errors++; $display("FAIL single_s_adr beat %0d got %h want %h", b, bus.s_adr_o, adr); end
         if (bus.m_ack_o[2] === 1'b1) ack_cnt++;
      end
      checks++; if (ack_cnt !== 4) begin errors++; $display("FAIL single_ack_count got %0d want 4", ack_cnt); end
      tick();
      bus.s_ack_i = 1'b0;
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      @(negedge clk);
      checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_release_s_cyc got %b want 0", bus.s_cyc_o); end
      tick();
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL single_release_grant got %b want 0000", bus.grant_o); end
      tick();
   endtask

   task automatic test_contention;
      logic [3:0] order [3];
      logic [3:0] cur, prev, g;
      int         n, gap, phase;
      apply_reset();
      bus.m_cyc_i = 4'b1011;
      bus.m_stb_i = 4'b1011;
      n = 0; gap = 0; phase = 0; cur = '0; prev = '0;
      for (int c = 0; c < 60; c++) begin
         if (n == 3 && phase == 0) break;
         if (c > 0) tick();
         if (phase == 1) begin
            bus.s_ack_i = 1'b1;
            phase = 2;
         end else if (phase == 2) begin
            bus.s_ack_i = 1'b0;
            bus.m_cyc_i = bus.m_cyc_i & ~cur;
            bus.m_stb_i = bus.m_stb_i & ~cur;
            phase = 0;
         end
         @(negedge clk);
         g = bus.grant_o;
         if (phase == 2) begin
            checks++; if (bus.m_ack_o !== cur) begin errors++; $display("FAIL cont_ack got %b want %b", bus.m_ack_o, cur); end
         end
         if (g == 4'b0000) begin
            gap++;
            if (n > 0) begin
               checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL cont_gap_s_cyc got %b want 0", bus.s_cyc_o); end
            end
         end else if (prev == 4'b0000) begin
            if (n < 3) order[n] = g;
            if (n > 0) begin
               checks++; if (gap !== 1) begin errors++; $display("FAIL cont_gap_len got %0d want 1", gap); end
            end
            n++;
            gap = 0;
            cur = g;
            phase = 1;
         end
         prev = g;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL cont_grant_count got %0d want 3", n); end
      checks++; if (order[0] !== 4'b0001) begin errors++; $display("FAIL cont_order0 got %b want 0001", order[0]); end
      checks++; if (order[1] !== 4'b0010) begin errors++; $display("FAIL cont_order1 got %b want 0010", order[1]); end
      checks++; if (order[2] !== 4'b1000) begin errors++; $display("FAIL cont_order2 got %b want 1000", order[2]); end
      idle_inputs();
      tick();
      tick();
   endtask

   // Entered with last_grant = 3 (master 3 was the last owner).
   task automatic test_fairness;
      logic [3:0] order [4];
      logic [3:0] exp_order [4];
      logic [3:0] cur, prev, g;
      int         n, phase;
      exp_order[0] = 4'b0001;
      exp_order[1] = 4'b0010;
      exp_order[2] = 4'b0001;
      exp_order[3] = 4'b0010;
      bus.m_cyc_i = 4'b0011;
      bus.m_stb_i = 4'b0011;
      n = 0; phase = 0; cur = '0; prev = '0;
      for (int c = 0; c < 80; c++) begin
         if (n == 4 && phase == 0) break;
         if (c > 0) tick();
         if (phase == 1) begin
            bus.s_ack_i = 1'b1;
            phase = 2;
         end else if (phase == 2) begin
            bus.s_ack_i = 1'b0;
            bus.m_cyc_i = bus.m_cyc_i & ~cur;
            bus.m_stb_i = bus.m_stb_i & ~cur;
            phase = 3;
         end else if (phase == 3) begin
            bus.m_cyc_i = bus.m_cyc_i | cur;
            bus.m_stb_i = bus.m_stb_i | cur;
            phase = 0;
         end
         @(negedge clk);
         g = bus.grant_o;
         if (g != 4'b0000 && prev == 4'b0000) begin
            if (n < 4) order[n] = g;
            if (n > 0) begin
               checks++; if (g === cur) begin errors++; $display("FAIL fair_repeat got %b twice in a row", g); end
            end
            n++;
            cur = g;
            phase = 1;
         end
         prev = g;
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL fair_grant_count got %0d want 4", n); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL fair_order%0d got %b want %b", i, order[i], exp_order[i]); end
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_ack_isolation;
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL iso_idle_ack got %b want 0000", bus.m_ack_o); end
      tick();
      bus.s_ack_i = 1'b0;
      bus.m_cyc_i = 4'b0010;
      bus.m_stb_i = 4'b0000;
      tick();
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b0010) begin errors++; $display("FAIL iso_grant got %b want 0010", bus.grant_o); end
      tick();
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL iso_nostb_ack got %b want 0000", bus.m_ack_o); end
      checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL iso_s_stb got %b want 0", bus.s_stb_o); end
      tick();
      bus.m_stb_i = 4'b0001;
      @(negedge clk);
      checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL iso_nonowner_ack got %b want 0000", bus.m_ack_o); end
      tick();
      bus.m_stb_i = 4'b0010;
      @(negedge clk);
      checks++; if (bus.m_ack_o !== 4'b0010) begin errors++; $display("FAIL iso_owner_ack got %b want 0010", bus.m_ack_o); end
      tick();
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_reset_mid_burst;
      bus.m_cyc_i = 4'b1000;
      bus.m_stb_i = 4'b1000;
      bus.m_we_i  = 4'b1000;
      bus.m_adr_i[3*AW +: AW] = 24'hABCDEF;
      bus.m_dat_i[3*DW +: DW] = 32'hCAFE_F00D;
      bus.m_sel_i[3*4 +: 4]   = 4'hF;
      tick();
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b1000) begin errors++; $display("FAIL rst_mid_grant got %b want 1000", bus.grant_o); end
      checks++; if (bus.s_we_o !== 1'b1) begin errors++; $display("FAIL rst_mid_s_we got %b want 1", bus.s_we_o); end
      checks++; if (bus.s_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_mid_s_dat got %h want cafef00d", bus.s_dat_o); end
      checks++; if (bus.s_sel_o !== 4'hF) begin errors++; $display("FAIL rst_mid_s_sel got %h want f", bus.s_sel_o); end
      #1;
      rst = 1'b1;
      #1;
      checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_mid_s_cyc got %b want 0", bus.s_cyc_o); end
      checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rst_mid_s_stb got %b want 0", bus.s_stb_o); end
      checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_grant_drop got %b want 0000", bus.grant_o); end
      tick();
      tick();
      rst = 1'b0;
      bus.m_cyc_i = 4'b1001;
      bus.m_stb_i = 4'b1001;
      bus.m_we_i  = 4'b0000;
      tick();
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL rst_mid_first_win got %b want 0001", bus.grant_o); end
      tick();
      idle_inputs();
      tick();
      tick();
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int         stall, err_at;
      logic [3:0] errval;
      apply_reset();
      bus.m_cyc_i = 4'b0011;
      bus.m_stb_i = 4'b0011;
      stall = 0; err_at = -1; errval = '0;
      for (int c = 0; c < 40; c++) begin
         tick();
         @(negedge clk);
         if (bus.s_stb_o === 1'b1 && bus.s_ack_i === 1'b0) stall++;
         if (bus.m_err_o !== 4'b0000) begin
            errval = bus.m_err_o;
            err_at = stall;
            break;
         end
      end
      checks++; if (err_at !== 16) begin errors++; $display("FAIL to_err_cycle got %0d want 16", err_at); end
      checks++; if (errval !== 4'b0001) begin errors++; $display("FAIL to_err_owner got %b want 0001", errval); end
      tick();
      bus.m_cyc_i[0] = 1'b0;
      bus.m_stb_i[0] = 1'b0;
      @(negedge clk);
      checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL to_s_cyc_drop got %b want 0", bus.s_cyc_o); end
      checks++; if (bus.m_err_o !== 4'b0000) begin errors++; $display("FAIL to_err_pulse got %b want 0000", bus.m_err_o); end
      tick();
      @(negedge clk);
      checks++; if (bus.grant_o !== 4'b0010) begin errors++; $display("FAIL to_next_grant got %b want 0010", bus.grant_o); end
      idle_inputs();
      tick();
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL sim_timeout bench did not finish within time limit");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_single_master();
      test_contention();
      test_fairness();
      test_ack_isolation();
      test_reset_mid_burst();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
